// File: rtl/lfsr_pkg.sv
// Shared constants and types for the 48-bit LFSR sequence checker:
// register width, feedback tap mask, generator seed and FSM state encodings.
package lfsr_pkg;

  localparam int LFSR_W = 48;
  localparam logic [LFSR_W-1:0] TAP_MASK = 48'hAAAA_AAAA_AAAA;
  localparam logic [LFSR_W-1:0] GEN_SEED = 48'h0F0F_F0F0_0F0F;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RSVD   = 2'd3
  } chk_state_t;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_fb_48.sv
// Combinational feedback for the 48-bit LFSR: parity of the state bits
// selected by the tap mask (every odd position).
module lfsr_fb_48
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_state,
  output logic              fb_bit
);

  logic [LFSR_W-1:0] tapped;

  generate
    for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_tap
      assign tapped[gi] = lfsr_state[gi] & TAP_MASK[gi];
    end
  endgenerate

  assign fb_bit = ^tapped;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising LFSR stream checker: fills a local model from the stream,
// verifies predictions before declaring lock, then flywheels and counts bit errors.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int FILL_W  = cnt_width(LFSR_W);
  localparam int MATCH_W = cnt_width(LOCK_CNT);
  localparam int WIN_W   = cnt_width(LOSS_WIN);
  localparam int WERR_W  = cnt_width(LOSS_THR);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THR - 1);

  chk_state_t          state_reg;
  logic [LFSR_W-1:0]   s_reg;
  logic [FILL_W-1:0]   fill_cnt_reg;
  logic [MATCH_W-1:0]  match_cnt_reg;
  logic [WIN_W-1:0]    win_cnt_reg;
  logic [WERR_W-1:0]   win_err_reg;
  logic                locked_reg;
  logic                err_pulse_reg;
  logic [CNT_W-1:0]    err_count_reg;

  logic pred_bit;
  logic mismatch;
  logic s_zero;
  logic err_sat;
  logic count_err;

  lfsr_fb_48 u_fb (
    .lfsr_state (s_reg),
    .fb_bit     (pred_bit)
  );

  assign mismatch  = bit_in ^ pred_bit;
  assign s_zero    = (s_reg == '0);
  assign err_sat   = &err_count_reg;
  assign count_err = bit_valid && (state_reg == ST_LOCKED) && mismatch;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_FILL;
      s_reg         <= '0;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_pulse_reg <= 1'b0;

      case (state_reg)
        ST_FILL: begin
          if (bit_valid) begin
            s_reg <= {s_reg[LFSR_W-2:0], bit_in};
            if (fill_cnt_reg == FILL_LAST) begin
              fill_cnt_reg <= '0;
              state_reg    <= ST_VERIFY;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end

        ST_VERIFY: begin
          if (bit_valid) begin
            s_reg <= {s_reg[LFSR_W-2:0], bit_in};
            // An all-zero model predicts zeros forever, so it must never count as a match.
            if (s_zero || mismatch) begin
              match_cnt_reg <= '0;
              fill_cnt_reg  <= '0;
              state_reg     <= ST_FILL;
            end else if (match_cnt_reg == MATCH_LAST) begin
              match_cnt_reg <= '0;
              win_cnt_reg   <= '0;
              win_err_reg   <= '0;
              locked_reg    <= 1'b1;
              state_reg     <= ST_LOCKED;
            end else begin
              match_cnt_reg <= match_cnt_reg + 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (bit_valid) begin
            s_reg <= {s_reg[LFSR_W-2:0], pred_bit};
            if (mismatch) begin
              err_pulse_reg <= 1'b1;
            end
            // Loss of lock outranks the window wrap on the same bit.
            if (mismatch && (win_err_reg == WERR_LAST)) begin
              fill_cnt_reg  <= '0;
              match_cnt_reg <= '0;
              win_cnt_reg   <= '0;
              win_err_reg   <= '0;
              locked_reg    <= 1'b0;
              state_reg     <= ST_FILL;
            end else if (win_cnt_reg == WIN_LAST) begin
              win_cnt_reg <= '0;
              win_err_reg <= '0;
            end else begin
              win_cnt_reg <= win_cnt_reg + 1'b1;
              if (mismatch) begin
                win_err_reg <= win_err_reg + 1'b1;
              end
            end
          end
        end

        default: begin
          fill_cnt_reg  <= '0;
          match_cnt_reg <= '0;
          win_cnt_reg   <= '0;
          win_err_reg   <= '0;
          locked_reg    <= 1'b0;
          state_reg     <= ST_FILL;
        end
      endcase

      if (clr_count) begin
        err_count_reg <= '0;
      end else if (count_err && !err_sat) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed lock/loss/saturation/reset scenarios plus
// randomized traffic compared each cycle against a queue-based reference model.
module tb_lfsr_seq_checker;
  import lfsr_pkg::*;

  localparam int LOCK_N = 16;
  localparam int WIN_N  = 64;
  localparam int THR_N  = 8;

  logic        system_clk = 1'b0;
  logic        rst_n;
  logic        bit_valid;
  logic        bit_in;
  logic        clr_count;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  state, state4;

  logic [47:0] gen_state;
  logic        gen_fb;

  always #5 system_clk = ~system_clk;

  lfsr_seq_checker #(.CNT_W(16), .LOCK_CNT(LOCK_N), .LOSS_WIN(WIN_N), .LOSS_THR(THR_N)) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clr_count  (clr_count),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .state      (state)
  );

  lfsr_seq_checker #(.CNT_W(4), .LOCK_CNT(LOCK_N), .LOSS_WIN(WIN_N), .LOSS_THR(THR_N)) dut4 (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clr_count  (clr_count),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
    .err_count  (err_count4),
    .state      (state4)
  );

  lfsr_fb_48 u_gen_fb (
    .lfsr_state (gen_state),
    .fb_bit     (gen_fb)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: history of received/predicted bits, newest at index 0.
  bit hist[$];
  int m_run;
  bit m_locked;
  int m_wbits, m_werrs;
  int m_err16, m_err4;
  bit m_pulse;

  typedef struct {
    bit v;
    bit flip;
    bit clr;
    bit e_locked;
    bit e_pulse;
    int e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(bit v, bit flip, bit clr, bit el, bit ep, int ec);
    vec_t r;
    r.v = v; r.flip = flip; r.clr = clr; r.e_locked = el; r.e_pulse = ep; r.e_cnt = ec;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit ref_parity(input logic [47:0] v);
    bit p = 1'b0;
    for (int i = 1; i < 48; i += 2) p ^= v[i];
    return p;
  endfunction

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int k = 1; k < 48; k += 2) p ^= hist[k];
    return p;
  endfunction

  function automatic int model_ones();
    int c = 0;
    foreach (hist[i]) if (hist[i]) c++;
    return c;
  endfunction

  task automatic push_hist(input bit b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 48; i++) hist.push_back(1'b0);
    m_run = 0; m_locked = 1'b0; m_wbits = 0; m_werrs = 0;
    m_err16 = 0; m_err4 = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit pred;
    bit miss;
    m_pulse = 1'b0;
    if (v) begin
      pred = model_pred();
      if (!m_locked) begin
        if (m_run >= 48) begin
          if (model_ones() == 0 || b != pred) begin
            m_run = 0;
          end else begin
            m_run++;
            if (m_run == 48 + LOCK_N) begin
              m_locked = 1'b1; m_run = 0; m_wbits = 0; m_werrs = 0;
            end
          end
        end else begin
          m_run++;
        end
        push_hist(b);
      end else begin
        push_hist(pred);
        miss = (b != pred);
        if (miss) begin
          m_pulse = 1'b1;
          if (m_err16 < 65535) m_err16++;
          if (m_err4 < 15) m_err4++;
          m_werrs++;
        end
        if (miss && m_werrs == THR_N) begin
          m_locked = 1'b0; m_run = 0;
        end else if (m_wbits == WIN_N - 1) begin
          m_wbits = 0; m_werrs = 0;
        end else begin
          m_wbits++;
        end
      end
    end
    if (clr) begin
      m_err16 = 0; m_err4 = 0;
    end
  endtask

  task automatic check_model();
    logic [1:0] es;
    es = m_locked ? 2'd2 : ((m_run < 48) ? 2'd0 : 2'd1);
    check("model16", {12'd0, state, locked, err_pulse, err_count},
          {12'd0, es, m_locked, m_pulse, m_err16[15:0]});
    check("model4", {24'd0, state4, locked4, err_pulse4, err_count4},
          {24'd0, es, m_locked, m_pulse, m_err4[3:0]});
  endtask

  task automatic tick_raw(input bit v, input bit b, input bit clr);
    bit_valid = v; bit_in = b; clr_count = clr;
    @(posedge system_clk);
    #1;
    cyc++;
    model_step(v, b, clr);
    check_model();
  endtask

  // Generator-driven bit: flip corrupts only the transmitted copy, not the generator.
  task automatic tick(input bit v, input bit flip, input bit clr);
    bit b;
    b = 1'b0;
    if (v) begin
      check("gen_fb", {31'd0, gen_fb}, {31'd0, ref_parity(gen_state)});
      b = gen_fb ^ flip;
      gen_state = {gen_state[46:0], gen_fb};
    end
    tick_raw(v, b, clr);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {8'd0, state, locked, err_pulse, err_count, state4, locked4, err_pulse4, err_count4}, 32'd0);
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; bit_in = 1'b0; clr_count = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge system_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic acquire();
    for (int i = 0; i < 63; i++) tick(1'b1, 1'b0, 1'b0);
    check("lock_pre", {31'd0, locked}, 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("lock_at_64", {31'd0, locked}, 32'd1);
  endtask

  initial begin
    bit ever_locked;
    int nvalid;
    bit v;

    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_count = 1'b0;
    gen_state = GEN_SEED;
    model_reset();
    repeat (2) @(posedge system_clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;

    // Clean acquisition from the seeded generator.
    acquire();
    check("cnt_after_lock", {16'd0, err_count}, 32'd0);
    $display("acquire: locked=%0d err_count=%0d", locked, err_count);

    // Error injection while locked: single error, then loss after 8 errors in the window.
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].v, vecs[i].flip, vecs[i].clr);
      check("vec_locked", {31'd0, locked}, {31'd0, vecs[i].e_locked});
      check("vec_pulse", {31'd0, err_pulse}, {31'd0, vecs[i].e_pulse});
      check("vec_cnt", {16'd0, err_count}, vecs[i].e_cnt);
      $display("vec %0d: valid=%0d flip=%0d locked=%0d err_pulse=%0d err_count=%0d",
               i, vecs[i].v, vecs[i].flip, locked, err_pulse, err_count);
    end

    // Relock: vec 16 already supplied the first good bit after loss.
    for (int i = 0; i < 62; i++) tick(1'b1, 1'b0, 1'b0);
    check("relock_pre", {31'd0, locked}, 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_cnt", {16'd0, err_count}, 32'd8);
    $display("relock: locked=%0d err_count=%0d", locked, err_count);

    // Saturation of the narrow counter, then clear on an error cycle.
    do_reset();
    acquire();
    for (int e = 0; e < 20; e++) begin
      for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
    end
    check("sat4", {28'd0, err_count4}, 32'd15);
    check("sat16", {16'd0, err_count}, 32'd20);
    check("sat_locked", {31'd0, locked}, 32'd1);
    tick(1'b1, 1'b1, 1'b1);
    check("clr_prio4", {28'd0, err_count4}, 32'd0);
    check("clr_prio16", {16'd0, err_count}, 32'd0);
    check("clr_pulse", {31'd0, err_pulse4}, 32'd1);
    $display("saturate: err_count4 before clear reached 15, after clear=%0d", err_count4);

    // All-zero stream must never lock.
    do_reset();
    ever_locked = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick_raw(1'b1, 1'b0, 1'b0);
      if (locked) ever_locked = 1'b1;
    end
    check("zero_never_lock", {31'd0, ever_locked}, 32'd0);
    check("zero_cnt", {16'd0, err_count}, 32'd0);
    $display("zero stream: ever_locked=%0d err_count=%0d", ever_locked, err_count);

    // Asynchronous reset mid-LOCKED during valid gaps, then relock with gaps.
    do_reset();
    acquire();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_mid_lock");
    @(posedge system_clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    model_reset();
    nvalid = 0;
    while (nvalid < 63) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) nvalid++;
      tick(v, 1'b0, 1'b0);
    end
    check("post_rst_pre", {31'd0, locked}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("post_rst_lock", {31'd0, locked}, 32'd1);
    $display("async reset: relocked=%0d after 64 valid bits", locked);

    // Randomized traffic: light then heavy error rates, occasional clears.
    do_reset();
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 1500; i++) begin
        tick(($urandom_range(0, 3) != 0),
             (seg == 0) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 149) == 0));
      end
      $display("random segment %0d: locked=%0d err_count=%0d", seg, locked, err_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
